// File: rtl/img_pkg.sv
// Shared image geometry, morphology mode encoding and sequencer states
// for the binary post-processing stages.
package img_pkg;

   localparam int WIDTH  = 256;
   localparam int HEIGHT = 256;
   localparam int ADDR_W = 16;

   localparam logic MODE_ERODE  = 1'b0;
   localparam logic MODE_DILATE = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } morph_state_e;

   // Out-of-image neighbours take the value that cannot change the result:
   // 1 for erode (AND), 0 for dilate (OR).
   function automatic logic pad_bit(input logic pix, input logic in_image, input logic mode);
      return in_image ? pix : ~mode;
   endfunction

endpackage

// File: rtl/bin_line_buf.sv
// One image row of delay for a 1-bit pixel stream: a DEPTH-deep shift
// register advanced only while shift_en is high.
module bin_line_buf
   import img_pkg::*;
#(
   parameter int DEPTH = WIDTH
) (
   input  logic clk,
   input  logic rst_n,
   input  logic shift_en,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] taps;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taps <= '0;
      end else if (shift_en) begin
         taps <= {taps[DEPTH-2:0], din};
      end
   end

   assign dout = taps[DEPTH-1];

endmodule

// File: rtl/bin_morph3x3.sv
// Raster-scans the binarizer map, applies a 3x3 erode/dilate and stores the
// cleaned image in an internal 1-bit map readable by address.
//
//   state | meaning
//   IDLE  | waiting for start, result map holds last run
//   RUN   | addressing pixels 0..N-1, one per cycle
//   FLUSH | WIDTH+1 padding pixels push the last rows through the window
//   DONE  | result complete, waiting for next start
module bin_morph3x3
   import img_pkg::*;
#(
   parameter int WIDTH  = img_pkg::WIDTH,
   parameter int HEIGHT = img_pkg::HEIGHT,
   parameter int ADDR_W = img_pkg::ADDR_W
) (
   input  logic              morph_clk,
   input  logic              morph_rst_n,
   input  logic              morph_ctrl,
   input  logic              morph_mode,
   output logic [ADDR_W-1:0] bin_address,
   input  logic              bin_data,
   input  logic [ADDR_W-1:0] out_address,
   output logic              out_data,
   output logic [1:0]        condition_led
);

   localparam int N     = WIDTH * HEIGHT;
   localparam int COL_W = $clog2(WIDTH);
   localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int TMR_W = COL_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
   localparam logic [ADDR_W-1:0] FILL_LEN  = ADDR_W'(WIDTH);
   localparam logic [TMR_W-1:0]  FLUSH_LEN = TMR_W'(WIDTH);

   morph_state_e      state, state_nxt;
   logic              mode;
   logic [ADDR_W-1:0] scan_cnt;
   logic [TMR_W-1:0]  flush_tmr;
   logic [ROW_W-1:0]  row;
   logic [COL_W-1:0]  col;
   logic [ADDR_W-1:0] wr_addr;
   logic              start, busy, wr_en, pix_in;
   logic              lb1_out, lb2_out;
   logic [2:0]        col_new, col_mid, col_old;
   logic              top_ok, bot_ok, left_ok, right_ok;
   logic [8:0]        win;
   logic              result;
   logic              map_mem [N];

   assign start   = morph_ctrl && ((state == IDLE) || (state == DONE));
   assign busy    = (state == RUN) || (state == FLUSH);
   assign pix_in  = (state == RUN) ? bin_data : ~mode;
   // Centre pixel p becomes complete once pixel p+WIDTH+1 is on the input.
   assign wr_en   = ((state == RUN) && (scan_cnt > FILL_LEN)) || (state == FLUSH);

   always_ff @(posedge morph_clk or negedge morph_rst_n) begin
      if (!morph_rst_n) state <= IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (morph_ctrl)              state_nxt = RUN;
         RUN:        if (scan_cnt == LAST_ADDR)   state_nxt = FLUSH;
         FLUSH:      if (flush_tmr == '0)         state_nxt = DONE;
         default:                                 state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge morph_clk or negedge morph_rst_n) begin
      if (!morph_rst_n) begin
         mode      <= MODE_ERODE;
         scan_cnt  <= '0;
         flush_tmr <= '0;
         row       <= '0;
         col       <= '0;
         wr_addr   <= '0;
      end else if (start) begin
         mode      <= morph_mode;
         scan_cnt  <= '0;
         flush_tmr <= FLUSH_LEN;
         row       <= '0;
         col       <= '0;
         wr_addr   <= '0;
      end else begin
         if ((state == RUN) && (scan_cnt != LAST_ADDR)) scan_cnt <= scan_cnt + 1'b1;
         if ((state == FLUSH) && (flush_tmr != '0))     flush_tmr <= flush_tmr - 1'b1;
         if (wr_en) begin
            wr_addr <= wr_addr + 1'b1;
            if (col == COL_W'(WIDTH - 1)) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   bin_line_buf #(.DEPTH(WIDTH)) u_lb1 (
      .clk(morph_clk), .rst_n(morph_rst_n), .shift_en(busy), .din(pix_in), .dout(lb1_out)
   );

   bin_line_buf #(.DEPTH(WIDTH)) u_lb2 (
      .clk(morph_clk), .rst_n(morph_rst_n), .shift_en(busy), .din(lb1_out), .dout(lb2_out)
   );

   // Window columns are {row-1, row, row+1}; the newest column is taken
   // straight from the stream so the last write lands on the FLUSH->DONE edge.
   assign col_new = {lb2_out, lb1_out, pix_in};

   always_ff @(posedge morph_clk or negedge morph_rst_n) begin
      if (!morph_rst_n) begin
         col_mid <= '0;
         col_old <= '0;
      end else if (busy) begin
         col_mid <= col_new;
         col_old <= col_mid;
      end
   end

   assign top_ok   = (row != '0);
   assign bot_ok   = (row != ROW_W'(HEIGHT - 1));
   assign left_ok  = (col != '0);
   assign right_ok = (col != COL_W'(WIDTH - 1));

   always_comb begin
      win    = '0;
      win[8] = pad_bit(col_old[2], top_ok && left_ok,  mode);
      win[7] = pad_bit(col_old[1], left_ok,            mode);
      win[6] = pad_bit(col_old[0], bot_ok && left_ok,  mode);
      win[5] = pad_bit(col_mid[2], top_ok,             mode);
      win[4] = col_mid[1];
      win[3] = pad_bit(col_mid[0], bot_ok,             mode);
      win[2] = pad_bit(col_new[2], top_ok && right_ok, mode);
      win[1] = pad_bit(col_new[1], right_ok,           mode);
      win[0] = pad_bit(col_new[0], bot_ok && right_ok, mode);
   end

   assign result = (mode == MODE_DILATE) ? |win : &win;

   // Result map deliberately has no reset: readback keeps the last image.
   always_ff @(posedge morph_clk) begin
      if (wr_en) map_mem[wr_addr] <= result;
   end

   assign out_data = map_mem[out_address];

   always_comb begin
      bin_address = '0;
      case (state)
         RUN:     bin_address = scan_cnt;
         FLUSH:   bin_address = LAST_ADDR;
         default: bin_address = '0;
      endcase
   end

   assign condition_led = {state == DONE, busy};

endmodule

// File: tb/tb_bin_morph3x3.sv
// Directed bench for bin_morph3x3 on a 16x16 image: busy length, borders,
// no-wrap columns, mid-run reset and ignored mid-run start.
module tb_bin_morph3x3;

   localparam int W        = 16;
   localparam int H        = 16;
   localparam int AW       = 8;
   localparam int N        = W * H;
   localparam int BUSY_LEN = N + W + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ctrl = 1'b0;
   logic          mode = 1'b0;
   logic [AW-1:0] bin_address;
   logic          bin_data;
   logic [AW-1:0] out_address = '0;
   logic          out_data;
   logic [1:0]    led;

   logic img     [N];
   logic exp_map [N];

   int n_checks = 0;
   int n_pass   = 0;

   bin_morph3x3 #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
      .morph_clk    (clk),
      .morph_rst_n  (rst_n),
      .morph_ctrl   (ctrl),
      .morph_mode   (mode),
      .bin_address  (bin_address),
      .bin_data     (bin_data),
      .out_address  (out_address),
      .out_data     (out_data),
      .condition_led(led)
   );

   always #5 clk = ~clk;

   assign bin_data = img[bin_address];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic fill_img(input logic v);
      for (int i = 0; i < N; i++) img[i] = v;
   endtask

   task automatic fill_exp(input logic v);
      for (int i = 0; i < N; i++) exp_map[i] = v;
   endtask

   task automatic set_px(input int r, input int c, input logic v);
      img[r*W + c] = v;
   endtask

   task automatic set_exp_rect(input int r0, input int r1, input int c0, input int c1, input logic v);
      for (int r = r0; r <= r1; r++)
         for (int c = c0; c <= c1; c++)
            exp_map[r*W + c] = v;
   endtask

   // Starts a run and counts busy cycles; optionally pulses start with the
   // opposite mode partway through RUN.
   task automatic run_op(input logic m, input int pulse_at, input string tag);
      int cnt;
      @(negedge clk);
      mode = m;
      ctrl = 1'b1;
      @(negedge clk);
      ctrl = 1'b0;
      check({tag, "_start_led"}, 32'(led), 32'd1);
      cnt = 0;
      while (led[0] === 1'b1 && cnt < 4 * BUSY_LEN) begin
         if (cnt == 20)    check({tag, "_scan_addr"}, 32'(bin_address), 32'd20);
         if (cnt == N + 5) check({tag, "_flush_addr"}, 32'(bin_address), 32'(N - 1));
         if (pulse_at > 0 && cnt == pulse_at) begin
            ctrl = 1'b1;
            mode = ~m;
         end else begin
            ctrl = 1'b0;
         end
         cnt++;
         @(negedge clk);
      end
      ctrl = 1'b0;
      check({tag, "_busy_len"}, 32'(cnt), 32'(BUSY_LEN));
      check({tag, "_done_led"}, 32'(led), 32'd2);
   endtask

   task automatic check_map(input string tag, input int exp_ones);
      int mism;
      int ones;
      mism = 0;
      ones = 0;
      for (int a = 0; a < N; a++) begin
         out_address = AW'(a);
         #1;
         if (out_data !== exp_map[a]) mism++;
         if (out_data === 1'b1) ones++;
      end
      check({tag, "_map_mismatches"}, 32'(mism), 32'd0);
      check({tag, "_ones"}, 32'(ones), 32'(exp_ones));
   endtask

   task automatic spot(input string tag, input int r, input int c, input logic v);
      out_address = AW'(r*W + c);
      #1;
      check(tag, 32'(out_data), 32'(v));
   endtask

   initial begin
      fill_img(1'b0);
      #12;
      check("reset_led", 32'(led), 32'd0);
      check("reset_addr", 32'(bin_address), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // all ones, erode: borders padded with 1 so nothing erodes away
      fill_img(1'b1);
      fill_exp(1'b1);
      run_op(1'b0, 0, "t1");
      check_map("t1", N);

      // single 1 at (10,10), dilate
      fill_img(1'b0);
      set_px(10, 10, 1'b1);
      fill_exp(1'b0);
      set_exp_rect(9, 11, 9, 11, 1'b1);
      run_op(1'b1, 0, "t2");
      check_map("t2", 9);

      // all ones with a hole at the top-left corner, erode
      fill_img(1'b1);
      set_px(0, 0, 1'b0);
      fill_exp(1'b1);
      set_exp_rect(0, 1, 0, 1, 1'b0);
      run_op(1'b0, 0, "t3");
      check_map("t3", N - 4);

      // single 1 on the right edge, dilate: must not wrap to column 0
      fill_img(1'b0);
      set_px(5, W - 1, 1'b1);
      fill_exp(1'b0);
      set_exp_rect(4, 6, W - 2, W - 1, 1'b1);
      run_op(1'b1, 0, "t4");
      check_map("t4", 6);
      spot("t4_nowrap_r4", 4, 0, 1'b0);
      spot("t4_nowrap_r5", 5, 0, 1'b0);
      spot("t4_nowrap_r6", 6, 0, 1'b0);
      spot("t4_edge_r5", 5, W - 2, 1'b1);

      // reset mid-run aborts at once, then a fresh run completes
      fill_img(1'b0);
      @(negedge clk);
      mode = 1'b1;
      ctrl = 1'b1;
      @(negedge clk);
      ctrl = 1'b0;
      repeat (100) @(negedge clk);
      check("t5_busy_before_rst", 32'(led), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_led", 32'(led), 32'd0);
      check("t5_rst_addr", 32'(bin_address), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_idle_after_rst", 32'(led), 32'd0);
      fill_img(1'b1);
      set_px(H - 1, W - 1, 1'b0);
      fill_exp(1'b1);
      set_exp_rect(H - 2, H - 1, W - 2, W - 1, 1'b0);
      run_op(1'b0, 0, "t5");
      check_map("t5", N - 4);

      // start pulse with the other mode during RUN is ignored
      fill_img(1'b0);
      set_px(7, 3, 1'b1);
      fill_exp(1'b0);
      set_exp_rect(6, 8, 2, 4, 1'b1);
      run_op(1'b1, 50, "t6");
      check_map("t6", 9);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
